// File: rtl/fpu_issue_ctrl_if.sv
// rtl/fpu_issue_ctrl_if.sv - issue/FPU/writeback/CSR bundle for fpu_issue_ctrl
// Purpose: groups every non-clock, non-reset signal of fpu_issue_ctrl.
//   slave  : the issue controller (takes pipeline, FPU and CSR inputs).
//   master : the pipeline/FPU/CSR side that drives those inputs.
// Signals: issue handshake (issueValid_i/issueReady_o, instr_i, rs1Int_i),
//   FPU side (fpuEnable_o, fpuInstr_o, fpuRs1..3_o, fpuRm_o, fpuBusy_i,
//   fpuOut_i, fpuFlags_i), integer writeback (intWbValid_o, intWbRd_o,
//   intWbData_o), CSR port (csrAddr_i, csrWe_i, csrWdata_i, csrRdata_o),
//   illegal_o pulse.
interface fpu_issue_ctrl_if;
  logic        issueValid_i;
  logic        issueReady_o;
  logic [31:0] instr_i;
  logic [31:0] rs1Int_i;
  logic        fpuEnable_o;
  logic [31:0] fpuInstr_o;
  logic [31:0] fpuRs1_o;
  logic [31:0] fpuRs2_o;
  logic [31:0] fpuRs3_o;
  logic [2:0]  fpuRm_o;
  logic        fpuBusy_i;
  logic [31:0] fpuOut_i;
  logic [4:0]  fpuFlags_i;
  logic        intWbValid_o;
  logic [4:0]  intWbRd_o;
  logic [31:0] intWbData_o;
  logic [11:0] csrAddr_i;
  logic        csrWe_i;
  logic [31:0] csrWdata_i;
  logic [31:0] csrRdata_o;
  logic        illegal_o;

  modport slave (
    input  issueValid_i, instr_i, rs1Int_i, fpuBusy_i, fpuOut_i, fpuFlags_i,
           csrAddr_i, csrWe_i, csrWdata_i,
    output issueReady_o, fpuEnable_o, fpuInstr_o, fpuRs1_o, fpuRs2_o, fpuRs3_o,
           fpuRm_o, intWbValid_o, intWbRd_o, intWbData_o, csrRdata_o, illegal_o
  );

  modport master (
    output issueValid_i, instr_i, rs1Int_i, fpuBusy_i, fpuOut_i, fpuFlags_i,
           csrAddr_i, csrWe_i, csrWdata_i,
    input  issueReady_o, fpuEnable_o, fpuInstr_o, fpuRs1_o, fpuRs2_o, fpuRs3_o,
           fpuRm_o, intWbValid_o, intWbRd_o, intWbData_o, csrRdata_o, illegal_o
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - RV32F issue controller: FP regfile, FPU sequencing, fflags/frm CSRs
// Purpose: accepts one FP instruction at a time, latches operands from the
//   32x32 FP register file (or the integer rs1 value), drives an external FPU
//   until it is not busy, then writes the result back to the FP register file
//   or to the integer writeback port, accumulating exception flags in fflags.
// Ports:
//   clk_i   - clock, all state on rising edge
//   reset_i - asynchronous active-low reset
//   bus     - fpu_issue_ctrl_if.slave (issue, FPU, writeback, CSR, illegal)
// Parameter FRM_RESET: frm value loaded at reset.
module fpu_issue_ctrl #(
  parameter logic [2:0] FRM_RESET = 3'b000
) (
  input logic             clk_i,
  input logic             reset_i,
  fpu_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_t;

  localparam logic [6:0] OP_FP = 7'b1010011;

  state_t      state;
  logic [31:0] freg [32];
  logic [4:0]  fflags;
  logic [2:0]  frm;
  logic [31:0] instr_q, rs1_q, rs2_q, rs3_q, res_q;
  logic [2:0]  rm_q;
  logic [4:0]  flags_q;
  logic        fpu_en_q, int_wb_q;

  // Decode of the instruction currently offered by the pipeline.
  logic [4:0] funct5;
  logic       is_opfp, is_fma, uses_rm, rm_bad, rs1_is_int;
  logic [2:0] rm_res;

  always_comb begin
    funct5     = bus.instr_i[31:27];
    is_opfp    = (bus.instr_i[6:0] == OP_FP);
    // FMADD/FMSUB/FNMSUB/FNMADD share 100xx11
    is_fma     = (bus.instr_i[6:4] == 3'b100) && (bus.instr_i[1:0] == 2'b11);
    uses_rm    = is_fma || (is_opfp && (funct5 inside {5'b00000, 5'b00001, 5'b00010,
                                                       5'b00011, 5'b01011, 5'b11000,
                                                       5'b11010}));
    rm_res     = (bus.instr_i[14:12] == 3'b111) ? frm : bus.instr_i[14:12];
    rm_bad     = uses_rm && (rm_res inside {3'b101, 3'b110, 3'b111});
    rs1_is_int = is_opfp && (funct5 inside {5'b11010, 5'b11110});
  end

  // Decode of the latched instruction, used in WB.
  logic [4:0] l_funct5;
  logic       l_opfp, l_int_dest, l_no_flags;

  always_comb begin
    l_funct5   = instr_q[31:27];
    l_opfp     = (instr_q[6:0] == OP_FP);
    l_int_dest = l_opfp && (l_funct5 inside {5'b10100, 5'b11000, 5'b11100});
    // sign-injection, moves and classify never raise exceptions
    l_no_flags = l_opfp && (l_funct5 inside {5'b00100, 5'b11100, 5'b11110});
  end

  // A CSR write landing in the WB cycle replaces the fflags base so neither
  // the software write nor the hardware accumulation is lost.
  logic [4:0] wb_base;

  always_comb begin
    wb_base = fflags;
    if (bus.csrWe_i && (bus.csrAddr_i == 12'h001 || bus.csrAddr_i == 12'h003))
      wb_base = bus.csrWdata_i[4:0];
  end

  always_comb begin
    case (bus.csrAddr_i)
      12'h001: bus.csrRdata_o = {27'b0, fflags};
      12'h002: bus.csrRdata_o = {29'b0, frm};
      12'h003: bus.csrRdata_o = {24'b0, frm, fflags};
      default: bus.csrRdata_o = 32'b0;
    endcase
  end

  logic unused_wdata;
  assign unused_wdata = ^bus.csrWdata_i[31:8];

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state    <= IDLE;
      fflags   <= 5'b0;
      frm      <= FRM_RESET;
      instr_q  <= 32'b0;
      rs1_q    <= 32'b0;
      rs2_q    <= 32'b0;
      rs3_q    <= 32'b0;
      rm_q     <= 3'b0;
      res_q    <= 32'b0;
      flags_q  <= 5'b0;
      fpu_en_q <= 1'b0;
      int_wb_q <= 1'b0;
      for (int i = 0; i < 32; i++) freg[i] <= 32'b0;
    end else begin
      int_wb_q <= 1'b0;
      if (bus.csrWe_i) begin
        case (bus.csrAddr_i)
          12'h001: fflags <= bus.csrWdata_i[4:0];
          12'h002: frm    <= bus.csrWdata_i[2:0];
          12'h003: begin
            frm    <= bus.csrWdata_i[7:5];
            fflags <= bus.csrWdata_i[4:0];
          end
          default: ;
        endcase
      end
      case (state)
        IDLE: begin
          if (bus.issueValid_i && !rm_bad) begin
            instr_q  <= bus.instr_i;
            rs1_q    <= rs1_is_int ? bus.rs1Int_i : freg[bus.instr_i[19:15]];
            rs2_q    <= freg[bus.instr_i[24:20]];
            rs3_q    <= freg[bus.instr_i[31:27]];
            rm_q     <= rm_res;
            fpu_en_q <= 1'b1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (!bus.fpuBusy_i) begin
            res_q    <= bus.fpuOut_i;
            flags_q  <= bus.fpuFlags_i;
            fpu_en_q <= 1'b0;
            int_wb_q <= l_int_dest;
            state    <= WB;
          end
        end
        WB: begin
          if (!l_int_dest) freg[instr_q[11:7]] <= res_q;
          // overrides any CSR fflags write above; wb_base already folds it in
          fflags <= wb_base | (l_no_flags ? 5'b0 : flags_q);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.issueReady_o = (state == IDLE);
  // Combinational so the rejection is seen in the same cycle as the offer;
  // gated by reset so nothing pulses while the block is held in reset.
  assign bus.illegal_o    = reset_i && (state == IDLE) && bus.issueValid_i && rm_bad;
  assign bus.fpuEnable_o  = fpu_en_q;
  assign bus.fpuInstr_o   = instr_q;
  assign bus.fpuRs1_o     = rs1_q;
  assign bus.fpuRs2_o     = rs2_q;
  assign bus.fpuRs3_o     = rs3_q;
  assign bus.fpuRm_o      = rm_q;
  assign bus.intWbValid_o = int_wb_q;
  assign bus.intWbRd_o    = instr_q[11:7];
  assign bus.intWbData_o  = res_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb/tb_fpu_issue_ctrl.sv - directed self-checking bench for fpu_issue_ctrl
module tb_fpu_issue_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fpu_issue_ctrl_if bus ();

  fpu_issue_ctrl #(.FRM_RESET(3'b010)) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus.slave)
  );

  localparam logic [6:0] OPFP = 7'b1010011;

  function automatic logic [31:0] enc(input logic [4:0] f5, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] rm,
                                      input logic [4:0] rd);
    return {f5, 2'b00, rs2, rs1, rm, rd, OPFP};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_rd(input logic [11:0] a, input string tag, input logic [31:0] exp);
    bus.csrAddr_i = a;
    #1;
    chk(tag, bus.csrRdata_o, exp);
  endtask

  task automatic accept(input logic [31:0] ins, input logic [31:0] rs1v);
    bus.instr_i      = ins;
    bus.rs1Int_i     = rs1v;
    bus.issueValid_i = 1'b1;
    tick();
    bus.issueValid_i = 1'b0;
  endtask

  // From EXEC with FPU not busy: go through WB and back to IDLE.
  task automatic complete_op(input logic [31:0] res, input logic [4:0] flg);
    bus.fpuOut_i   = res;
    bus.fpuFlags_i = flg;
    bus.fpuBusy_i  = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.issueValid_i = 1'b0;
    bus.instr_i      = 32'b0;
    bus.rs1Int_i     = 32'b0;
    bus.fpuBusy_i    = 1'b0;
    bus.fpuOut_i     = 32'b0;
    bus.fpuFlags_i   = 5'b0;
    bus.csrAddr_i    = 12'b0;
    bus.csrWe_i      = 1'b0;
    bus.csrWdata_i   = 32'b0;
    tick();
    tick();

    // reset state
    chk("rst_ready", bus.issueReady_o, 1);
    chk("rst_fpu_en", bus.fpuEnable_o, 0);
    chk("rst_intwb", bus.intWbValid_o, 0);
    chk("rst_illegal", bus.illegal_o, 0);
    chk("rst_instr", bus.fpuInstr_o, 0);
    csr_rd(12'h002, "rst_frm", 32'h2);
    csr_rd(12'h001, "rst_fflags", 32'h0);
    rst_n = 1'b1;
    tick();

    // load f1, f2 via FMV.W.X (rs1 comes from the integer side)
    accept(enc(5'b11110, 5'd0, 5'd0, 3'b000, 5'd1), 32'h3F800000);
    chk("fmv_rs1_int", bus.fpuRs1_o, 32'h3F800000);
    complete_op(32'h3F800000, 5'b0);
    accept(enc(5'b11110, 5'd0, 5'd0, 3'b000, 5'd2), 32'h40000000);
    complete_op(32'h40000000, 5'b0);

    // FADD.S f3,f1,f2 rm=000, cycle-exact latency
    bus.instr_i      = enc(5'b00000, 5'd2, 5'd1, 3'b000, 5'd3);
    bus.rs1Int_i     = 32'hDEADBEEF;
    bus.issueValid_i = 1'b1;
    #1;
    chk("fadd_n_ready", bus.issueReady_o, 1);
    chk("fadd_n_illegal", bus.illegal_o, 0);
    tick();
    bus.issueValid_i = 1'b0;
    chk("fadd_n1_en", bus.fpuEnable_o, 1);
    chk("fadd_n1_ready", bus.issueReady_o, 0);
    chk("fadd_rs1", bus.fpuRs1_o, 32'h3F800000);
    chk("fadd_rs2", bus.fpuRs2_o, 32'h40000000);
    chk("fadd_rm", bus.fpuRm_o, 32'h0);
    bus.fpuOut_i   = 32'h40400000;
    bus.fpuFlags_i = 5'b00001;
    tick();
    chk("fadd_n2_en", bus.fpuEnable_o, 0);
    chk("fadd_n2_ready", bus.issueReady_o, 0);
    chk("fadd_n2_intwb", bus.intWbValid_o, 0);
    tick();
    chk("fadd_n3_ready", bus.issueReady_o, 1);
    csr_rd(12'h001, "fadd_fflags", 32'h01);

    // FSGNJ.S f4,f3,f3: reads back f3; its flags must not accumulate
    accept(enc(5'b00100, 5'd3, 5'd3, 3'b000, 5'd4), 32'h0);
    chk("f3_value", bus.fpuRs1_o, 32'h40400000);
    complete_op(32'h40400000, 5'b01000);
    csr_rd(12'h001, "fsgnj_no_flags", 32'h01);

    // FDIV.S f6,f1,f2 rm=001 with 5 busy cycles
    accept(enc(5'b00011, 5'd2, 5'd1, 3'b001, 5'd6), 32'h0);
    chk("fdiv_rm", bus.fpuRm_o, 32'h1);
    bus.fpuBusy_i  = 1'b1;
    bus.fpuOut_i   = 32'h3F000000;
    bus.fpuFlags_i = 5'b10000;
    for (int i = 0; i < 5; i++) begin
      chk("fdiv_en_busy", bus.fpuEnable_o, 1);
      chk("fdiv_rs2_stable", bus.fpuRs2_o, 32'h40000000);
      tick();
    end
    bus.fpuBusy_i = 1'b0;
    chk("fdiv_en_6th", bus.fpuEnable_o, 1);
    tick();
    chk("fdiv_n7_en", bus.fpuEnable_o, 0);
    chk("fdiv_n7_ready", bus.issueReady_o, 0);
    tick();
    chk("fdiv_n8_ready", bus.issueReady_o, 1);
    csr_rd(12'h001, "fflags_accum", 32'h11);
    csr_rd(12'h003, "fcsr_accum", 32'h51);

    // fcsr write
    bus.csrAddr_i  = 12'h003;
    bus.csrWdata_i = 32'hE0;
    bus.csrWe_i    = 1'b1;
    tick();
    bus.csrWe_i = 1'b0;
    csr_rd(12'h002, "fcsr_wr_frm", 32'h7);
    csr_rd(12'h001, "fcsr_wr_fflags", 32'h0);
    csr_rd(12'h003, "fcsr_rd", 32'hE0);
    csr_rd(12'h004, "csr_other", 32'h0);

    // frm=101, FMUL.S dynamic rm -> illegal, no EXEC
    bus.csrAddr_i  = 12'h002;
    bus.csrWdata_i = 32'h5;
    bus.csrWe_i    = 1'b1;
    tick();
    bus.csrWe_i      = 1'b0;
    bus.instr_i      = enc(5'b00010, 5'd2, 5'd1, 3'b111, 5'd9);
    bus.issueValid_i = 1'b1;
    #1;
    chk("fmul_illegal", bus.illegal_o, 1);
    tick();
    bus.issueValid_i = 1'b0;
    #1;
    chk("illegal_one_cycle", bus.illegal_o, 0);
    chk("illegal_stay_idle", bus.issueReady_o, 1);
    chk("illegal_no_exec", bus.fpuEnable_o, 0);
    chk("illegal_instr_kept", bus.fpuInstr_o, enc(5'b00011, 5'd2, 5'd1, 3'b001, 5'd6));
    csr_rd(12'h001, "illegal_no_flags", 32'h0);

    // FLT.S x5 -> integer writeback; CSR fflags write lands in its WB cycle
    accept(enc(5'b10100, 5'd2, 5'd1, 3'b001, 5'd5), 32'h0);
    bus.fpuOut_i   = 32'h1;
    bus.fpuFlags_i = 5'b00100;
    tick();
    chk("flt_intwb_valid", bus.intWbValid_o, 1);
    chk("flt_intwb_rd", bus.intWbRd_o, 32'd5);
    chk("flt_intwb_data", bus.intWbData_o, 32'h1);
    bus.csrAddr_i  = 12'h001;
    bus.csrWdata_i = 32'h2;
    bus.csrWe_i    = 1'b1;
    tick();
    bus.csrWe_i = 1'b0;
    chk("flt_intwb_pulse_end", bus.intWbValid_o, 0);
    csr_rd(12'h001, "fflags_merge", 32'h06);
    accept(enc(5'b00100, 5'd5, 5'd5, 3'b000, 5'd7), 32'h0);
    chk("f5_unchanged", bus.fpuRs1_o, 32'h0);
    complete_op(32'h0, 5'b0);

    // reset in EXEC
    accept(enc(5'b00100, 5'd1, 5'd1, 3'b000, 5'd8), 32'h0);
    bus.fpuBusy_i = 1'b1;
    chk("exec_before_rst", bus.fpuEnable_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_exec_en", bus.fpuEnable_o, 0);
    chk("rst_exec_ready", bus.issueReady_o, 1);
    tick();
    bus.fpuBusy_i = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_intwb", bus.intWbValid_o, 0);
      chk("post_rst_en", bus.fpuEnable_o, 0);
      tick();
    end
    chk("post_rst_instr", bus.fpuInstr_o, 32'h0);
    csr_rd(12'h002, "post_rst_frm", 32'h2);
    csr_rd(12'h001, "post_rst_fflags", 32'h0);
    accept(enc(5'b00100, 5'd1, 5'd1, 3'b000, 5'd9), 32'h0);
    chk("post_rst_f1_cleared", bus.fpuRs1_o, 32'h0);
    complete_op(32'h0, 5'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
